nway_tag_lookup: RTL and testbench

Parametrised N-way tag-match and replacement unit for the set-associative caches. It compares a lookup tag against all ways' stored tags and valid bits, and registers the result with one cycle of latency. It also owns the per-set tree-PLRU state and reports a victim way for misses. It sits between the tag/valid SRAM read ports and the cache controller, and replaces per-way single-tag comparators.

---
 rtl/cache_types_pkg.sv | 60 ++++++
 rtl/nway_tag_lookup_if.sv | 32 +++
 rtl/onehot_to_bin_prio.sv | 31 +++
 rtl/nway_tag_lookup.sv | 76 +++++++
 tb/tb_nway_tag_lookup.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cache_types_pkg.sv
// Shared cache types and tree-PLRU helpers used by the set-associative caches.
package cache_types_pkg;

   localparam int unsigned s_way     = 2;
   localparam int unsigned s_way_num = 1 << s_way;
   localparam int unsigned s_plru    = s_way_num - 1;
   localparam int unsigned s_offset  = 5;
   localparam int unsigned s_index   = 4;
   localparam int unsigned s_tag     = 32 - s_offset - s_index;
   localparam int unsigned num_sets  = 1 << s_index;

   typedef logic [s_way-1:0]     way_t;
   typedef logic [s_index-1:0]   index_t;
   typedef logic [s_tag-1:0]     tag_t;
   typedef logic [s_plru-1:0]    plru_t;
   typedef logic [s_way_num-1:0] wayvec_t;
   typedef logic [s_way-1:0]     node_t;

   // Stage-1 lookup result, also the payload driven back to the controller.
   typedef struct packed {
      logic    valid;
      logic    hit;
      wayvec_t onehot;
      way_t    way;
      logic    multi;
      way_t    victim;
      index_t  index;
   } resp_t;

   // Walk from the root: a 0 bit steers left, a 1 bit steers right.
   function automatic way_t plru_victim(input plru_t bits);
      way_t  w;
      node_t node;
      logic  b;
      w    = '0;
      node = '0;
      for (int unsigned d = 0; d < s_way; d++) begin
         b    = bits[node];
         w    = way_t'((32'(w) << 1) | 32'(b));
         node = node_t'(32'(node) * 2 + 32'(b) + 1);
      end
      return w;
   endfunction

   // Point every node on the path of w away from w.
   function automatic plru_t plru_touch(input plru_t bits, input way_t w);
      plru_t res;
      node_t node;
      logic  dir;
      res  = bits;
      node = '0;
      for (int unsigned d = 0; d < s_way; d++) begin
         dir       = 1'(32'(w) >> (s_way - 1 - d));
         res[node] = ~dir;
         node      = node_t'(32'(node) * 2 + 32'(dir) + 1);
      end
      return res;
   endfunction

endpackage

// File: rtl/nway_tag_lookup_if.sv
// Lookup/fill request and registered lookup response between controller and tag unit.
interface nway_tag_lookup_if;
   import cache_types_pkg::*;

   logic                       lookup_valid;
   index_t                     lookup_index;
   tag_t                       lookup_tag;
   logic [s_way_num*s_tag-1:0] tags_in;
   wayvec_t                    valid_in;
   logic                       fill_valid;
   index_t                     fill_index;
   way_t                       fill_way;
   logic                       resp_valid;
   logic                       hit;
   wayvec_t                    hit_onehot;
   way_t                       hit_way;
   logic                       multi_hit;
   way_t                       victim_way;

   modport master (
      output lookup_valid, lookup_index, lookup_tag, tags_in, valid_in,
             fill_valid, fill_index, fill_way,
      input  resp_valid, hit, hit_onehot, hit_way, multi_hit, victim_way
   );

   modport slave (
      input  lookup_valid, lookup_index, lookup_tag, tags_in, valid_in,
             fill_valid, fill_index, fill_way,
      output resp_valid, hit, hit_onehot, hit_way, multi_hit, victim_way
   );

endinterface

// File: rtl/onehot_to_bin_prio.sv
// Lowest-index priority encoder with any/multiple-bit detection.
module onehot_to_bin_prio
   import cache_types_pkg::*;
(
   input  wayvec_t onehot,
   output way_t    way_c,
   output logic    any_c,
   output logic    multi_c
);

   wayvec_t lowest_c;

   // Mask of vector positions whose index has bit b set.
   function automatic wayvec_t bit_mask(input int unsigned b);
      wayvec_t m;
      m = '0;
      for (int unsigned i = 0; i < s_way_num; i++) begin
         m = m | (wayvec_t'((i >> b) & 1) << i);
      end
      return m;
   endfunction

   assign lowest_c = onehot & (~onehot + wayvec_t'(1));
   assign any_c    = |onehot;
   assign multi_c  = |(onehot & (onehot - wayvec_t'(1)));

   for (genvar b = 0; b < s_way; b++) begin : g_enc
      assign way_c[b] = |(lowest_c & bit_mask(b));
   end

endmodule

// File: rtl/nway_tag_lookup.sv
// N-way tag match with one cycle of latency plus per-set tree-PLRU victim selection.
module nway_tag_lookup
   import cache_types_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   nway_tag_lookup_if.slave   bus
);

   plru_t   plru_q [num_sets];
   plru_t   plru_d [num_sets];
   resp_t   s1_q;
   resp_t   s1_d;
   wayvec_t match_c;
   way_t    enc_way_c;
   logic    any_c;
   logic    multi_c;
   way_t    victim_c;
   logic    hit_touch_c;

   for (genvar w = 0; w < s_way_num; w++) begin : g_match
      assign match_c[w] = (bus.tags_in[w*s_tag +: s_tag] == bus.lookup_tag) && bus.valid_in[w];
   end

   onehot_to_bin_prio u_prio (
      .onehot  (match_c),
      .way_c   (enc_way_c),
      .any_c   (any_c),
      .multi_c (multi_c)
   );

   assign hit_touch_c = s1_q.valid && s1_q.hit;

   // Hit touch first so a same-set fill ends up most recent.
   always_comb begin
      plru_d = plru_q;
      if (hit_touch_c) begin
         plru_d[s1_q.index] = plru_touch(plru_d[s1_q.index], s1_q.way);
      end
      if (bus.fill_valid) begin
         plru_d[bus.fill_index] = plru_touch(plru_d[bus.fill_index], bus.fill_way);
      end
   end

   // Victim sees this cycle's pending touches so back-to-back lookups stay current.
   assign victim_c = plru_victim(plru_d[bus.lookup_index]);

   always_comb begin
      s1_d        = '0;
      s1_d.valid  = bus.lookup_valid;
      s1_d.hit    = any_c;
      s1_d.onehot = match_c;
      s1_d.way    = enc_way_c;
      s1_d.multi  = multi_c;
      s1_d.victim = victim_c;
      s1_d.index  = bus.lookup_index;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q   <= '0;
         plru_q <= '{default: '0};
      end else begin
         s1_q   <= s1_d;
         plru_q <= plru_d;
      end
   end

   assign bus.resp_valid = s1_q.valid;
   assign bus.hit        = s1_q.hit;
   assign bus.hit_onehot = s1_q.onehot;
   assign bus.hit_way    = s1_q.way;
   assign bus.multi_hit  = s1_q.multi;
   assign bus.victim_way = s1_q.victim;

endmodule

// File: tb/tb_nway_tag_lookup.sv
// Randomised and directed bench for nway_tag_lookup against a tree-PLRU reference model.
module tb_nway_tag_lookup;
   import cache_types_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   nway_tag_lookup_if bus ();

   nway_tag_lookup dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   int m_plru [num_sets];
   bit p_valid, p_hit;
   int p_way, p_idx;
   bit e_valid, e_hit, e_multi, e_reset;
   int e_onehot, e_way, e_victim;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Node at depth d on the path of way w sits at (2^d - 1) + (w >> (levels - d)).
   function automatic int m_victim(input int bits);
      int w = 0;
      for (int d = 0; d < s_way; d++) begin
         w = w * 2 + ((bits >> ((1 << d) - 1 + w)) & 1);
      end
      return w;
   endfunction

   function automatic int m_touch(input int bits, input int w);
      int r = bits;
      for (int d = 0; d < s_way; d++) begin
         int node = (1 << d) - 1 + (w >> (s_way - d));
         int dir  = (w >> (s_way - 1 - d)) & 1;
         if (dir == 1) r = r & ~(1 << node);
         else          r = r | (1 << node);
      end
      return r;
   endfunction

   task automatic drive(input bit lv, input int idx, input int tag, input int hitmask,
                        input int vmask, input bit fv = 1'b0, input int fidx = 0,
                        input int fway = 0);
      bus.lookup_valid = lv;
      bus.lookup_index = index_t'(idx);
      bus.lookup_tag   = tag_t'(tag);
      for (int w = 0; w < s_way_num; w++) begin
         if (((hitmask >> w) & 1) == 1) bus.tags_in[w*s_tag +: s_tag] = tag_t'(tag);
         else bus.tags_in[w*s_tag +: s_tag] = tag_t'(tag ^ ((w + 1) << 16));
      end
      bus.valid_in   = wayvec_t'(vmask);
      bus.fill_valid = fv;
      bus.fill_index = index_t'(fidx);
      bus.fill_way   = way_t'(fway);
   endtask

   task automatic step(input string name);
      int m, lw, li;
      e_reset = !rst;
      if (!rst) begin
         for (int s = 0; s < num_sets; s++) m_plru[s] = 0;
         p_valid = 0; p_hit = 0; p_way = 0; p_idx = 0;
         e_valid = 0; e_hit = 0; e_multi = 0; e_onehot = 0; e_way = 0; e_victim = 0;
      end else begin
         if (p_valid && p_hit) m_plru[p_idx] = m_touch(m_plru[p_idx], p_way);
         if (bus.fill_valid)
            m_plru[int'(bus.fill_index)] = m_touch(m_plru[int'(bus.fill_index)], int'(bus.fill_way));
         m = 0;
         for (int w = 0; w < s_way_num; w++) begin
            if (bus.valid_in[w] && (bus.tags_in[w*s_tag +: s_tag] == bus.lookup_tag)) m |= (1 << w);
         end
         lw = 0;
         for (int w = s_way_num - 1; w >= 0; w--) if (((m >> w) & 1) == 1) lw = w;
         li       = int'(bus.lookup_index);
         e_valid  = bus.lookup_valid;
         e_hit    = (m != 0);
         e_onehot = m;
         e_way    = lw;
         e_multi  = ($countones(m) > 1);
         e_victim = m_victim(m_plru[li]);
         p_valid  = e_valid;
         p_hit    = e_hit;
         p_way    = lw;
         p_idx    = li;
      end
      @(posedge clk);
      #1;
      check({name, ".resp_valid"}, 32'(bus.resp_valid), 32'(e_valid));
      if (e_valid || e_reset) begin
         check({name, ".hit"},        32'(bus.hit),        32'(e_hit));
         check({name, ".hit_onehot"}, 32'(bus.hit_onehot), 32'(e_onehot));
         check({name, ".hit_way"},    32'(bus.hit_way),    32'(e_way));
         check({name, ".multi_hit"},  32'(bus.multi_hit),  32'(e_multi));
         check({name, ".victim_way"}, 32'(bus.victim_way), 32'(e_victim));
      end
      @(negedge clk);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      step("reset0");
      step("reset1");
      rst = 1'b1;

      drive(1, 3, 32'h00777, 0, 4'b0000);
      step("idle_miss");

      for (int w = 0; w < s_way_num; w++) begin
         drive(0, 0, 0, 0, 0, 1'b1, 5, w);
         step("fill5");
      end
      drive(1, 5, 32'h12345, 4'b0001, 4'b1111);
      step("set5_hit0");
      drive(1, 5, 32'h00042, 0, 4'b1111);
      step("set5_after");
      drive(0, 0, 0, 0, 0);
      step("idle");

      drive(1, 7, 32'h00333, 4'b1000, 4'b1111);
      step("set7_hit3");
      drive(1, 7, 32'h00444, 0, 4'b1111);
      step("set7_bypass");

      drive(1, 2, 32'h00555, 4'b0001, 4'b1111);
      step("set2_hit0");
      drive(1, 2, 32'h00666, 0, 4'b1111, 1'b1, 2, 3);
      step("set2_same");
      drive(1, 2, 32'h00666, 0, 4'b1111);
      step("set2_next");

      drive(1, 9, 32'h00ABC, 4'b0110, 4'b0110);
      step("multi");
      drive(1, 9, 32'h00DEF, 0, 4'b1111);
      step("multi_after");

      drive(1, 11, 32'h00111, 4'b0100, 4'b1111);
      step("pre_reset_hit");
      rst = 1'b0;
      drive(1, 11, 32'h00222, 0, 4'b1111, 1'b1, 11, 1);
      step("mid_reset");
      rst = 1'b1;
      drive(1, 11, 32'h00222, 0, 4'b1111);
      step("post_reset");

      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(63) == 0) ? 1'b0 : 1'b1;
         drive(1'($urandom_range(1)), $urandom_range(3), 32'h100 + $urandom_range(3),
               $urandom_range(15), $urandom_range(15),
               ($urandom_range(9) < 3), $urandom_range(3), $urandom_range(3));
         step("rand");
      end
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
